nibble_unpacker: RTL and testbench
==================================

NIBBLE_UNPACKER -- requirements
Module: nibble_unpacker

Interface
REQ-001 The block SHALL have parameter HI_FIRST, default 0; 0 = low nibble emitted first, 1 = high nibble emitted first.
REQ-002 The block SHALL have parameter SKIP_ZERO_HI, default 0; 1 = a byte with data_in[7:4]==0 is emitted as a single nibble.
REQ-003 The block SHALL have port reg_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reg_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data_in, input, 8 bits: byte to unpack.
REQ-006 The block SHALL have port in_valid, input, 1 bit: data_in is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The block SHALL have port data_out, output, 4 bits: current nibble.
REQ-009 The block SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes data_out this cycle.
REQ-011 The block SHALL have port out_last, output, 1 bit: the current nibble is the final nibble of its byte.
REQ-012 The block SHALL have port busy, output, 1 bit: a byte is held, i.e. the state is not IDLE.

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-014 The FSM SHALL have exactly three states: IDLE, FIRST and LAST.
REQ-015 IDLE SHALL drive out_valid=0 and in_ready=1.
REQ-016 On an input transfer in IDLE, the byte SHALL be latched into an 8-bit holding register and the next state SHALL be FIRST.
REQ-017 Exception to REQ-016: if SKIP_ZERO_HI=1 and data_in[7:4]==0, the next state SHALL be LAST with the low nibble selected.
REQ-018 FIRST SHALL drive out_valid=1 and out_last=0.
REQ-019 In FIRST, data_out SHALL be held[3:0] when HI_FIRST=0 and held[7:4] when HI_FIRST=1.
REQ-020 FIRST SHALL drive in_ready=0, and SHALL go to LAST on an output transfer; otherwise it holds state and data_out stable.
REQ-021 LAST SHALL drive out_valid=1, out_last=1, and data_out equal to the nibble not yet sent (or the low nibble in the SKIP_ZERO_HI case).
REQ-022 In LAST, in_ready SHALL equal out_ready (combinational), giving back-to-back throughput.
REQ-023 On an output transfer in LAST with no input transfer, the next state SHALL be IDLE.
REQ-024 On an output transfer in LAST with a simultaneous input transfer, the new byte SHALL be latched and the next state SHALL be FIRST, or LAST if the skip rule applies; there SHALL be no IDLE bubble.
REQ-025 data_out, out_valid and out_last SHALL be decoded only from state and the holding register; there SHALL be no combinational path from data_in to data_out.
REQ-026 Latency SHALL be one cycle: the first nibble of an accepted byte is valid in the cycle after acceptance.
REQ-027 Sustained throughput SHALL be one byte per 2 cycles, or one per cycle for skipped bytes, when out_ready is held at 1.
REQ-028 data_out and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 The block SHALL place no constraint on out_ready while out_valid=0.
REQ-030 in_valid while in_ready=0 SHALL have no effect; the producer SHALL hold data_in.
REQ-031 busy SHALL be high in FIRST and LAST and low in IDLE.

Reset
REQ-032 While reg_rst_n=0, the block SHALL immediately, without waiting for a clock edge, force: state=IDLE, holding register=8'h00, out_valid=0, out_last=0, data_out=4'h0, busy=0, in_ready=1.
REQ-033 Reset asserted mid-byte SHALL discard the held byte; no remaining nibble is emitted after release.
REQ-034 Release of reg_rst_n SHALL be synchronised by the integrator; the block SHALL accept input on the first rising edge after release.

Verification
REQ-035 Default parameters, data_in=8'hA5, in_valid pulse, out_ready=1 -> the following cycles show data_out=4'h5, out_last=0, then 4'hA, out_last=1, then out_valid=0.
REQ-036 HI_FIRST=1, data_in=8'h3C -> 4'h3 then 4'hC with out_last on 4'hC.
REQ-037 SKIP_ZERO_HI=1, data_in=8'h07 then 8'h12 back-to-back -> 4'h7(last), 4'h2, 4'h1(last) in 3 consecutive cycles; in_ready high in the 8'h07 LAST cycle.
REQ-038 out_ready=0 for 5 cycles in FIRST -> data_out, out_last and out_valid are stable and in_ready=0 throughout, then normal completion.
REQ-039 Continuous in_valid with bytes 8'h01..8'h04 and out_ready=1 -> 8 nibbles in 8 cycles with no IDLE gap.
REQ-040 reg_rst_n pulsed low asynchronously between edges while in LAST -> out_valid drops before the next edge; no nibble appears after release until a new byte is accepted.

Source files
------------

// File: rtl/nibble_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : nibble_unpacker
// Description : Splits each accepted byte into two 4-bit nibbles on a
//               valid/ready stream. Optionally emits the high nibble first
//               and optionally collapses bytes with a zero high nibble to a
//               single nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_unpacker #(
    parameter logic HI_FIRST     = 1'b0,
    parameter logic SKIP_ZERO_HI = 1'b0
) (
    input  logic       reg_clk,
    input  logic       reg_rst_n,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_LAST  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_held;
    logic [3:0] r_data_out;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_busy;

    logic       w_in_xfer;
    logic       w_out_xfer;
    logic       w_skip;
    logic [3:0] w_load_nibble;
    logic [3:0] w_second_nibble;

    // A new byte may enter when idle, or when the last nibble leaves this cycle.
    assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_LAST) && out_ready);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // A byte with an empty high nibble goes straight to LAST when skipping is on.
    assign w_skip          = SKIP_ZERO_HI && (data_in[7:4] == 4'h0);
    assign w_load_nibble   = (w_skip || !HI_FIRST) ? data_in[3:0] : data_in[7:4];
    assign w_second_nibble = HI_FIRST ? r_held[3:0] : r_held[7:4];

    // Sequencer: state, holding register and all stream outputs are registered.
    // An input transfer can only happen in IDLE or on the final output
    // transfer of LAST, so it always means "load a new byte".
    always_ff @(posedge reg_clk or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            r_state     <= ST_IDLE;
            r_held      <= 8'h00;
            r_data_out  <= 4'h0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_in_xfer) begin
            r_held      <= data_in;
            r_data_out  <= w_load_nibble;
            r_out_valid <= 1'b1;
            r_out_last  <= w_skip;
            r_busy      <= 1'b1;
            r_state     <= w_skip ? ST_LAST : ST_FIRST;
        end else begin
            case (r_state)
                ST_FIRST: begin
                    if (w_out_xfer) begin
                        r_state    <= ST_LAST;
                        r_data_out <= w_second_nibble;
                        r_out_last <= 1'b1;
                    end
                end
                ST_LAST: begin
                    if (w_out_xfer) begin
                        r_state     <= ST_IDLE;
                        r_data_out  <= 4'h0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_data_out  <= 4'h0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nibble_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_unpacker
// Description : Directed bench for nibble_unpacker. Three instances share the
//               stimulus: default parameters, high-nibble-first, and
//               zero-high-nibble skipping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_unpacker;

    logic       reg_clk = 1'b0;
    logic       reg_rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       w_ir0, w_ov0, w_ol0, w_bz0;
    logic [3:0] w_do0;
    logic       w_ir1, w_ov1, w_ol1, w_bz1;
    logic [3:0] w_do1;
    logic       w_ir2, w_ov2, w_ol2, w_bz2;
    logic [3:0] w_do2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 reg_clk = ~reg_clk;

    nibble_unpacker u_dut0 (
        .reg_clk(reg_clk), .reg_rst_n(reg_rst_n), .data_in(data_in),
        .in_valid(in_valid), .in_ready(w_ir0), .data_out(w_do0),
        .out_valid(w_ov0), .out_ready(out_ready), .out_last(w_ol0), .busy(w_bz0)
    );

    nibble_unpacker #(.HI_FIRST(1'b1), .SKIP_ZERO_HI(1'b0)) u_dut1 (
        .reg_clk(reg_clk), .reg_rst_n(reg_rst_n), .data_in(data_in),
        .in_valid(in_valid), .in_ready(w_ir1), .data_out(w_do1),
        .out_valid(w_ov1), .out_ready(out_ready), .out_last(w_ol1), .busy(w_bz1)
    );

    nibble_unpacker #(.HI_FIRST(1'b0), .SKIP_ZERO_HI(1'b1)) u_dut2 (
        .reg_clk(reg_clk), .reg_rst_n(reg_rst_n), .data_in(data_in),
        .in_valid(in_valid), .in_ready(w_ir2), .data_out(w_do2),
        .out_valid(w_ov2), .out_ready(out_ready), .out_last(w_ol2), .busy(w_bz2)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_v;
        logic [3:0] e_d;
        logic       e_l;
        logic       e_ir;
        logic       e_b;
    } vec_t;

    localparam int c_NVEC = 26;
    vec_t tbl [c_NVEC];

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                                input logic e_v, input logic [3:0] e_d, input logic e_l,
                                input logic e_ir, input logic e_b);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_v = e_v; v.e_d = e_d; v.e_l = e_l; v.e_ir = e_ir; v.e_b = e_b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
    endtask

    task automatic next_cycle();
        @(posedge reg_clk);
        #1;
    endtask

    // Assert reset, check the default instance's forced values, release on a
    // falling edge and return just after the following rising edge.
    task automatic do_reset(input string tag);
        reg_rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        #1;
        chk({tag, ".rst.valid"}, {7'd0, w_ov0}, 8'd0);
        chk({tag, ".rst.last"},  {7'd0, w_ol0}, 8'd0);
        chk({tag, ".rst.data"},  {4'd0, w_do0}, 8'd0);
        chk({tag, ".rst.busy"},  {7'd0, w_bz0}, 8'd0);
        chk({tag, ".rst.ready"}, {7'd0, w_ir0}, 8'd1);
        @(negedge reg_clk);
        reg_rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        // Default instance: single byte, backpressure in FIRST and LAST,
        // back-to-back bytes 01..04, and a refused input in LAST.
        tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1);
        tbl[3]  = mk(1'b1, 8'h5B, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
        tbl[12] = mk(1'b1, 8'h01, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 8'h02, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
        tbl[14] = mk(1'b1, 8'h02, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
        tbl[15] = mk(1'b1, 8'h03, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
        tbl[16] = mk(1'b1, 8'h03, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
        tbl[17] = mk(1'b1, 8'h04, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        tbl[18] = mk(1'b1, 8'h04, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
        tbl[19] = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
        tbl[21] = mk(1'b1, 8'hC3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tbl[22] = mk(1'b1, 8'h99, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        tbl[23] = mk(1'b1, 8'h99, 1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1);
        tbl[24] = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1);
        tbl[25] = mk(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        do_reset("init");
        for (int i = 0; i < c_NVEC; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            @(negedge reg_clk);
            chk($sformatf("tbl[%0d].valid", i), {7'd0, w_ov0}, {7'd0, tbl[i].e_v});
            chk($sformatf("tbl[%0d].ready", i), {7'd0, w_ir0}, {7'd0, tbl[i].e_ir});
            chk($sformatf("tbl[%0d].busy", i),  {7'd0, w_bz0}, {7'd0, tbl[i].e_b});
            if (tbl[i].e_v) begin
                chk($sformatf("tbl[%0d].data", i), {4'd0, w_do0}, {4'd0, tbl[i].e_d});
                chk($sformatf("tbl[%0d].last", i), {7'd0, w_ol0}, {7'd0, tbl[i].e_l});
            end
            next_cycle();
        end

        // High nibble first: 3C -> 3, then C with last.
        do_reset("hi");
        drive(1'b1, 8'h3C, 1'b1);
        @(negedge reg_clk);
        chk("hi.c0.ready", {7'd0, w_ir1}, 8'd1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge reg_clk);
        chk("hi.c1.valid", {7'd0, w_ov1}, 8'd1);
        chk("hi.c1.data",  {4'd0, w_do1}, 8'h03);
        chk("hi.c1.last",  {7'd0, w_ol1}, 8'd0);
        next_cycle();
        @(negedge reg_clk);
        chk("hi.c2.valid", {7'd0, w_ov1}, 8'd1);
        chk("hi.c2.data",  {4'd0, w_do1}, 8'h0C);
        chk("hi.c2.last",  {7'd0, w_ol1}, 8'd1);
        next_cycle();
        @(negedge reg_clk);
        chk("hi.c3.valid", {7'd0, w_ov1}, 8'd0);

        // Skip zero high nibble: 07 then 12 back-to-back -> 7(last), 2, 1(last).
        do_reset("skip");
        drive(1'b1, 8'h07, 1'b1);
        @(negedge reg_clk);
        chk("skip.c0.ready", {7'd0, w_ir2}, 8'd1);
        next_cycle();
        drive(1'b1, 8'h12, 1'b1);
        @(negedge reg_clk);
        chk("skip.c1.valid", {7'd0, w_ov2}, 8'd1);
        chk("skip.c1.data",  {4'd0, w_do2}, 8'h07);
        chk("skip.c1.last",  {7'd0, w_ol2}, 8'd1);
        chk("skip.c1.ready", {7'd0, w_ir2}, 8'd1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge reg_clk);
        chk("skip.c2.valid", {7'd0, w_ov2}, 8'd1);
        chk("skip.c2.data",  {4'd0, w_do2}, 8'h02);
        chk("skip.c2.last",  {7'd0, w_ol2}, 8'd0);
        next_cycle();
        @(negedge reg_clk);
        chk("skip.c3.valid", {7'd0, w_ov2}, 8'd1);
        chk("skip.c3.data",  {4'd0, w_do2}, 8'h01);
        chk("skip.c3.last",  {7'd0, w_ol2}, 8'd1);
        next_cycle();
        @(negedge reg_clk);
        chk("skip.c4.valid", {7'd0, w_ov2}, 8'd0);
        chk("skip.c4.busy",  {7'd0, w_bz2}, 8'd0);

        // Asynchronous reset while in LAST, then a new byte on the first
        // rising edge after release.
        do_reset("arst");
        drive(1'b1, 8'hA5, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge reg_clk);
        chk("arst.first.data", {4'd0, w_do0}, 8'h05);
        next_cycle();
        drive(1'b0, 8'h00, 1'b0);
        @(negedge reg_clk);
        chk("arst.last.data",  {4'd0, w_do0}, 8'h0A);
        chk("arst.last.last",  {7'd0, w_ol0}, 8'd1);
        #2;
        reg_rst_n = 1'b0;
        #1;
        chk("arst.mid.valid", {7'd0, w_ov0}, 8'd0);
        chk("arst.mid.last",  {7'd0, w_ol0}, 8'd0);
        chk("arst.mid.busy",  {7'd0, w_bz0}, 8'd0);
        chk("arst.mid.ready", {7'd0, w_ir0}, 8'd1);
        #1;
        reg_rst_n = 1'b1;
        drive(1'b1, 8'h6E, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge reg_clk);
        chk("arst.new.valid", {7'd0, w_ov0}, 8'd1);
        chk("arst.new.data",  {4'd0, w_do0}, 8'h0E);
        chk("arst.new.last",  {7'd0, w_ol0}, 8'd0);
        next_cycle();
        @(negedge reg_clk);
        chk("arst.new2.data", {4'd0, w_do0}, 8'h06);
        chk("arst.new2.last", {7'd0, w_ol0}, 8'd1);
        next_cycle();
        @(negedge reg_clk);
        chk("arst.end.valid", {7'd0, w_ov0}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
